ibex_fpu_regfile_sb: RTL
========================

IBEX_FPU_REGFILE_SB -- requirements
Module: ibex_fpu_regfile_sb

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter NumReadPorts, default 3, number of independent read ports (1..3).
REQ-003 SHALL have parameter WriteBypass, default 0; when 1, reads return same-cycle write data.
REQ-004 SHALL have port clk_int  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port raddr_i  input  NumReadPorts x 5  read addresses.
REQ-007 SHALL have port rdata_o  output  NumReadPorts x DataWidth  read data.
REQ-008 SHALL have port rbusy_o  output  NumReadPorts  scoreboard pending bit of each read address.
REQ-009 SHALL have ports we_a_i/waddr_a_i/wdata_a_i/single_a_i  input  1/5/DataWidth/1  write port A (FPU result).
REQ-010 SHALL have ports we_b_i/waddr_b_i/wdata_b_i/single_b_i  input  1/5/DataWidth/1  write port B (FP load).
REQ-011 SHALL have ports sb_set_i/sb_addr_i  input  1/5  mark destination register pending at issue.
REQ-012 SHALL have port sb_flush_i  input  1  clear all pending bits.
REQ-013 SHALL have port busy_any_o  output  1  OR of all 32 pending bits.

Function
REQ-014 SHALL hold 32 flip-flop words f0..f31; f0 is a normal writable register (no hard-wired zero).
REQ-015 SHALL update the addressed word one cycle after we_x_i sampled high; write latency 1 cycle.
REQ-016 SHALL, when DataWidth=64 and single_x_i=1, store wdata[31:0] with bits [63:32] forced to all ones (NaN-boxing); single_x_i ignored when DataWidth=32.
REQ-017 SHALL, when both ports write the same address in one cycle, store port A data; port B write dropped.
REQ-018 SHALL with WriteBypass=0 return the pre-write (registered) value on a same-cycle read of a written address.
REQ-019 SHALL with WriteBypass=1 return the (NaN-boxed) write data combinationally, port A having priority over port B.
REQ-020 SHALL set pending[sb_addr_i] on the edge where sb_set_i=1.
REQ-021 SHALL clear pending[waddr] on the edge where that address is written by either port.
REQ-022 SHALL, on simultaneous set and write-clear of the same address, leave the bit set (new owner wins).
REQ-023 SHALL, when sb_flush_i=1, clear all pending bits, overriding sb_set_i in the same cycle; register contents unaffected.
REQ-024 SHALL drive rbusy_o[i] = pending[raddr_i[i]] combinationally, without bypass of same-cycle set/clear.
REQ-025 SHALL treat writes to a non-pending register as legal (contents updated, bit stays 0).

Reset
REQ-026 SHALL on rst_ni low clear all 32 words to 0 and all pending bits to 0 asynchronously.
REQ-027 SHALL drive rdata_o=0, rbusy_o=0, busy_any_o=0 while in reset; writes/sets during reset ignored.
REQ-028 SHALL resume normal operation on the first clk_int edge after rst_ni deasserts.

Structure
REQ-029 SHALL take typedef fp_reg_addr_t (5 bits) and constant FpNumRegs=32 from ibex_pkg.
REQ-030 SHALL implement pending-bit logic in one sub-module ibex_fpu_scoreboard (set/clear/flush, lookup).
REQ-031 SHALL contain no latches and no clock gating cells.

Verification
REQ-032 SHALL cover: reset, read all ports addr 0..31 -> rdata_o=0, rbusy_o=0, busy_any_o=0.
REQ-033 SHALL cover: DataWidth=64, write A f5=0x3F800000 single=1 -> next cycle read f5=0xFFFFFFFF3F800000.
REQ-034 SHALL cover: same cycle A writes f3=0x11, B writes f3=0x22 -> f3=0x11.
REQ-035 SHALL cover: sb_set f7, then write B f7 while sb_set f7 same cycle -> rbusy for f7 stays 1; next write clears it.
REQ-036 SHALL cover: WriteBypass=0 vs 1, write f9=0xAB, read f9 same cycle -> old value vs 0xAB.
REQ-037 SHALL cover: set f1,f2,f30 then sb_flush_i with sb_set f4 -> busy_any_o=0 next cycle, contents unchanged.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared FP register file types and helpers.
package ibex_pkg;

  localparam int unsigned FpNumRegs   = 32;
  localparam int unsigned FpAddrWidth = 5;

  typedef logic [FpAddrWidth-1:0] fp_reg_addr_t;

  // Write-port control carried from the register file into the scoreboard.
  typedef struct packed {
    logic         we;
    fp_reg_addr_t addr;
  } fp_wr_req_t;

  // One-hot decode of an FP register address.
  function automatic logic [FpNumRegs-1:0] fp_reg_onehot(input fp_reg_addr_t addr);
    fp_reg_onehot = FpNumRegs'(1) << addr;
  endfunction

endpackage

// File: rtl/ibex_fpu_scoreboard.sv
// Pending-bit scoreboard for the FP register file: set at issue, cleared on
// writeback, flushed wholesale; lookups reflect registered state only.
module ibex_fpu_scoreboard import ibex_pkg::*; #(
  parameter int unsigned NumReadPorts = 3
) (
  input  logic                                  clk_int,
  input  logic                                  rst_ni,
  input  logic                                  set,
  input  fp_reg_addr_t                          set_addr,
  input  logic                                  flush,
  input  fp_wr_req_t                            clr_a,
  input  fp_wr_req_t                            clr_b,
  input  logic [NumReadPorts-1:0][FpAddrWidth-1:0] raddr,
  output logic [NumReadPorts-1:0]               rbusy,
  output logic                                  busy_any
);

  logic [FpNumRegs-1:0] pending_q;
  logic [FpNumRegs-1:0] pending_d;

  // Next pending state: clears first so a same-cycle set re-claims the register;
  // flush overrides everything.
  always_comb begin
    pending_d = pending_q;
    if (clr_a.we) pending_d = pending_d & ~fp_reg_onehot(clr_a.addr);
    if (clr_b.we) pending_d = pending_d & ~fp_reg_onehot(clr_b.addr);
    if (set)      pending_d = pending_d | fp_reg_onehot(set_addr);
    if (flush)    pending_d = '0;
  end

  // Pending-bit register.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Per-port lookup and global busy flag.
  always_comb begin
    rbusy = '0;
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      rbusy[p] = pending_q[raddr[p]];
    end
    busy_any = |pending_q;
  end

endmodule

// File: rtl/ibex_fpu_regfile_sb.sv
// FP register file (32 flop words, two write ports, N read ports) with an
// attached pending-bit scoreboard.
module ibex_fpu_regfile_sb import ibex_pkg::*; #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumReadPorts = 3,
  parameter bit          WriteBypass  = 1'b0
) (
  input  logic                                     clk_int,
  input  logic                                     rst_ni,
  input  logic [NumReadPorts-1:0][FpAddrWidth-1:0] raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumReadPorts-1:0]                  rbusy_o,
  input  logic                                     we_a_i,
  input  logic [FpAddrWidth-1:0]                   waddr_a_i,
  input  logic [DataWidth-1:0]                     wdata_a_i,
  input  logic                                     single_a_i,
  input  logic                                     we_b_i,
  input  logic [FpAddrWidth-1:0]                   waddr_b_i,
  input  logic [DataWidth-1:0]                     wdata_b_i,
  input  logic                                     single_b_i,
  input  logic                                     sb_set_i,
  input  logic [FpAddrWidth-1:0]                   sb_addr_i,
  input  logic                                     sb_flush_i,
  output logic                                     busy_any_o
);

  // Upper-half ones for NaN-boxing; all zero when DataWidth is 32.
  localparam logic [DataWidth-1:0] BoxMask = ~DataWidth'(32'hFFFF_FFFF);

  logic [DataWidth-1:0] regs_q [FpNumRegs];
  logic [DataWidth-1:0] wdata_a_box;
  logic [DataWidth-1:0] wdata_b_box;
  fp_wr_req_t           wr_a;
  fp_wr_req_t           wr_b;
  logic                 we_b_eff;

  // Write requests are suppressed while in reset so bypass cannot leak data.
  always_comb begin
    wr_a.we     = we_a_i & rst_ni;
    wr_a.addr   = waddr_a_i;
    wr_b.we     = we_b_i & rst_ni;
    wr_b.addr   = waddr_b_i;
    we_b_eff    = wr_b.we & ~(wr_a.we & (waddr_a_i == waddr_b_i));
    wdata_a_box = single_a_i ? (wdata_a_i | BoxMask) : wdata_a_i;
    wdata_b_box = single_b_i ? (wdata_b_i | BoxMask) : wdata_b_i;
  end

  // Register array; port A wins an address collision.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FpNumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (we_b_eff) regs_q[waddr_b_i] <= wdata_b_box;
      if (wr_a.we)  regs_q[waddr_a_i] <= wdata_a_box;
    end
  end

  // Read muxes with optional same-cycle write bypass (A before B).
  always_comb begin
    rdata_o = '0;
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      rdata_o[p] = regs_q[raddr_i[p]];
      if (WriteBypass) begin
        if (wr_a.we && (waddr_a_i == raddr_i[p])) begin
          rdata_o[p] = wdata_a_box;
        end else if (wr_b.we && (waddr_b_i == raddr_i[p])) begin
          rdata_o[p] = wdata_b_box;
        end
      end
    end
  end

  ibex_fpu_scoreboard #(
    .NumReadPorts (NumReadPorts)
  ) u_scoreboard (
    .clk_int  (clk_int),
    .rst_ni   (rst_ni),
    .set      (sb_set_i),
    .set_addr (sb_addr_i),
    .flush    (sb_flush_i),
    .clr_a    (wr_a),
    .clr_b    (wr_b),
    .raddr    (raddr_i),
    .rbusy    (rbusy_o),
    .busy_any (busy_any_o)
  );

endmodule
